// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the IF stage. Decode and the debug unit use
// the same values, so keep them here.
//   PC_W              : width of the word-index program counter
//   NOP_WORD          : instruction encoding injected on flush/squash
//   HALT_WORD_DEFAULT : encoding that stops fetch
//   ST_RUN / ST_HALT  : fetch state encoding, the same as the halted flag
package instruction_fetch_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP_WORD          = 32'h0000_0000;
    localparam instr_t HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Word-index increment; 10-bit modulo, so 1023 wraps to 0.
    function automatic pc_t pc_incr(input pc_t p);
        return p + pc_t'(1);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Pipeline-side bundle of the IF stage.
//   master : pipeline control (hazard unit, decode, MEM, debug) drives the
//            redirect/stall/enable inputs and observes IF/ID and PC state
//   slave  : the fetch stage itself
// Controls : clkEnable, PCSrc, branchTarget, jumpFlag, jumpTarget, inHazard
// Results  : Instruction, PCCount (IF/ID register), pc, halted
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic   clkEnable;
    logic   PCSrc;
    pc_t    branchTarget;
    logic   jumpFlag;
    pc_t    jumpTarget;
    logic   inHazard;
    instr_t Instruction;
    pc_t    PCCount;
    pc_t    pc;
    logic   halted;

    modport master (
        output clkEnable, PCSrc, branchTarget, jumpFlag, jumpTarget, inHazard,
        input  Instruction, PCCount, pc, halted
    );

    modport slave (
        input  clkEnable, PCSrc, branchTarget, jumpFlag, jumpTarget, inHazard,
        output Instruction, PCCount, pc, halted
    );

endinterface

// File: rtl/instruction_fetch_imem.sv
// Instruction memory: word-addressed ROM with a combinational read.
//   addr_i : 10-bit word index
//   data_o : 32-bit instruction at addr_i
// Contents are supplied by the environment.
module instruction_memory
    import instruction_fetch_pkg::*;
#(
    parameter int    MEM_DEPTH     = 1024,
    parameter string MEM_INIT_FILE = "program.hex"
) (
    input  pc_t    addr_i,
    output instr_t data_o
);

    instr_t mem [MEM_DEPTH];

    assign data_o = mem[addr_i];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline. Holds the PC, reads instruction
// memory and drives the IF/ID register. All state moves on the falling edge
// so that decode sees a stable IF/ID for the whole following half-cycle.
//   clk    : single clock, falling-edge active
//   reset  : asynchronous, active-low; clears PC, IF/ID and halt
//   bus    : instruction_fetch_if.slave -- redirect/stall/enable controls in,
//            IF/ID register, current PC and sticky halt flag out
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int     MEM_DEPTH     = 1024,
    parameter string  MEM_INIT_FILE = "program.hex",
    parameter instr_t HALT_WORD     = HALT_WORD_DEFAULT
) (
    input logic               clk,
    input logic               reset,
    instruction_fetch_if.slave bus
);

    pc_t        pc_q, pc_d;
    instr_t     instr_q, instr_d;
    pc_t        pccount_q, pccount_d;
    logic [0:0] state_q, state_d;
    instr_t     fetch_word;

    instruction_memory #(
        .MEM_DEPTH     (MEM_DEPTH),
        .MEM_INIT_FILE (MEM_INIT_FILE)
    ) u_imem (
        .addr_i (pc_q),
        .data_o (fetch_word)
    );

    // Priority: branch > halt > jump > stall > sequential fetch. A branch
    // outranks the halt so the debug unit can still observe a resolved
    // branch, but it never leaves HALT; only reset does.
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        pccount_d = pccount_q;
        state_d   = state_q;
        if (bus.clkEnable) begin
            if (bus.PCSrc) begin
                pc_d      = bus.branchTarget;
                instr_d   = NOP_WORD;
                pccount_d = '0;
            end else if (state_q == ST_HALT) begin
                instr_d   = NOP_WORD;
                pccount_d = '0;
            end else if (bus.jumpFlag) begin
                // The word behind the jump was fetched sequentially; squash it.
                pc_d      = bus.jumpTarget;
                instr_d   = NOP_WORD;
                pccount_d = '0;
            end else if (bus.inHazard) begin
                pc_d      = pc_q;
            end else begin
                instr_d   = fetch_word;
                pccount_d = pc_incr(pc_q);
                if (fetch_word == HALT_WORD) begin
                    // The halt word still goes to IF/ID; decode treats it as a NOP.
                    state_d = ST_HALT;
                end else begin
                    pc_d    = pc_incr(pc_q);
                end
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= '0;
            instr_q   <= NOP_WORD;
            pccount_q <= '0;
            state_q   <= ST_RUN;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pccount_q <= pccount_d;
            state_q   <= state_d;
        end
    end

    assign bus.Instruction = instr_q;
    assign bus.PCCount     = pccount_q;
    assign bus.pc          = pc_q;
    assign bus.halted      = (state_q == ST_HALT);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

IF stage of the 5-stage MIPS pipeline. Holds the program counter, reads the instruction memory, and drives the IF/ID pipeline register consumed by the decode stage (`Instruction`, `PCCount`). Applies the pipeline's redirect and stall controls: branch redirect/flush (`PCSrc`), jump redirect (`jumpFlag` from decode), load-use stall (`inHazard`), and a sticky halt used by the debug unit.

## Interface

Parameters:
- `MEM_DEPTH`, 1024: instruction memory words; PC is a word index, 10 bits.
- `MEM_INIT_FILE`, "program.hex": `$readmemh` image for instruction memory.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops fetch.

Ports:
- `clk`  in  1: single clock. All state updates on the falling edge, matching the decode stage.
- `reset`  in  1: asynchronous, active-low. Clears all state immediately.
- `clkEnable`  in  1: debug step gate. When 0, no state changes.
- `PCSrc`  in  1: branch taken, resolved in MEM. Redirects the PC and flushes IF/ID.
- `branchTarget`  in  10: branch destination, word index.
- `jumpFlag`  in  1: decode sees a `j` in IF/ID.
- `jumpTarget`  in  10: `Instruction[9:0]` of the jump in IF/ID.
- `inHazard`  in  1: load-use stall from the hazard unit.
- `Instruction`  out  32: IF/ID instruction register.
- `PCCount`  out  10: IF/ID register holding PC+1 of the fetched instruction.
- `pc`  out  10: current PC, for the debug unit.
- `halted`  out  1: sticky halt flag.

## Operation

- Reset values (asserted asynchronously while `reset`=0): `pc`=0, `Instruction`=0 (NOP), `PCCount`=0, `halted`=0.
- Fetch word is `imem[pc]`, read combinationally.
- Each enabled falling edge evaluates the cases below in strict priority order:
  1. **PCSrc=1:** `pc`←`branchTarget`; `Instruction`←0; `PCCount`←0. `halted` is unchanged, and this fetch cannot set it.
  2. **halted=1:** `pc` holds; `Instruction`←0; `PCCount`←0.
  3. **jumpFlag=1:** `pc`←`jumpTarget`; `Instruction`←0 (squashes the sequential slot); `PCCount`←0.
  4. **inHazard=1:** `pc`, `Instruction` and `PCCount` all hold.
  5. **Normal:** `Instruction`←`imem[pc]`; `PCCount`←`pc+1`; `pc`←`pc+1`.
     - If `imem[pc]`==`HALT_WORD`, `halted`←1 and `pc` holds instead of incrementing.
     - The halt word itself is latched into IF/ID; decode treats it as a NOP.
- State machine:
  - States: RUN (`halted`=0) and HALT (`halted`=1).
  - RUN→HALT only via case 5 with the halt word.
  - HALT→RUN only via reset.
- Arithmetic: `pc+1` is 10-bit modulo, so 1023 wraps to 0. Targets are used as-is, with no range check.

## Timing

- Latency: the word at `pc`=N appears on `Instruction` after the next enabled falling edge, with `PCCount`=N+1.
- Redirect penalty:
  - Jump: one flushed slot.
  - Branch: the flush here plus the decode/EX flushes owned by their stages.
- Simultaneous events:
  - `PCSrc`+`jumpFlag`: the branch wins, because the jump belongs to a squashed path.
  - `jumpFlag`+`inHazard`: the jump wins.
  - `PCSrc`+`inHazard`: the branch wins.
- `clkEnable`=0 freezes everything, including a pending redirect. The inputs are re-sampled at the next enabled edge.
- Reset deasserted mid-program: fetch restarts at 0 on the first enabled falling edge after release.

## Structure

- Shared package: `HALT_WORD`, the NOP constant (32'h0), and the 10-bit PC width constant. Decode and the debug unit use the same values.
- One sub-module, `instruction_memory`:
  - Parameterised by `MEM_DEPTH` and `MEM_INIT_FILE`.
  - 10-bit address in, 32-bit data out, combinational read.
- PC register, IF/ID register and halt flag live in `instruction_fetch`.

## Test plan

- **Reset and sequential fetch:** hold `reset`=0, then release; imem[0..2]=A,B,C. Required: after each of 3 enabled edges, `Instruction`=A/B/C with `PCCount`=1/2/3, and `pc`=3.
- **Stall:** `inHazard`=1 for 2 edges while `pc`=5. Required: `pc`=5 and `Instruction`/`PCCount` unchanged for both edges, then normal fetch of imem[5].
- **Jump, then branch priority:**
  - `jumpFlag`=1, `jumpTarget`=40. Required next edge: `Instruction`=0, `pc`=40.
  - Assert `PCSrc`=1, `branchTarget`=100 together with `jumpFlag`. Required: `pc`=100, `Instruction`=0.
- **Halt:** imem[7]=HALT_WORD, fetch from 6.
  - Required: the edge fetching 7 latches the halt word and sets `halted`=1 with `pc`=7.
  - Subsequent edges give `Instruction`=0.
  - A mid-program `reset` pulse clears `halted` and sets `pc`=0.
- **Wrap and clkEnable:** `pc`=1023. Required: one edge gives `PCCount`=0 (1023+1 wrapped) and `pc`=0. With `clkEnable`=0 plus `PCSrc`=1 for 3 edges, nothing changes.
